// File: rtl/lc3_mem_pkg.sv
// Shared constants and helpers for the LC3 memory responder.
// Memory-mapped register addresses, status bit position and window decode.
package lc3_mem_pkg;

   localparam logic [15:0] MMIO_BASE = 16'hFE00;
   localparam logic [15:0] KBSR_ADDR = 16'hFE00;
   localparam logic [15:0] KBDR_ADDR = 16'hFE02;
   localparam logic [15:0] DSR_ADDR  = 16'hFE04;
   localparam logic [15:0] DDR_ADDR  = 16'hFE06;
   localparam int          READY_BIT = 15;

   function automatic logic is_mmio(input logic [15:0] addr);
      return addr >= MMIO_BASE;
   endfunction

endpackage

// File: rtl/lc3_mmio_regs.sv
// LC3 keyboard/display device registers: KBSR/KBDR buffer, DSR with busy
// counter, display pulse, and the combinational MMIO read mux.
module lc3_mmio_regs
   import lc3_mem_pkg::*;
#(
   parameter int DISP_DELAY = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] mar,
   input  logic [7:0]  wr_char,
   input  logic        memwe,
   input  logic        ld_en,
   input  logic        kbd_valid,
   input  logic [7:0]  kbd_data,
   output logic        kbd_ready,
   output logic        ddr_valid,
   output logic [7:0]  ddr_data,
   output logic [15:0] mmio_rdata
);

   logic       kbsr_q, kbsr_d;
   logic [7:0] kbdr_q, kbdr_d;
   logic       dsr_q, dsr_d;
   logic [7:0] cnt_q, cnt_d;
   logic       ddr_valid_q, ddr_valid_d;
   logic [7:0] ddr_data_q, ddr_data_d;
   logic       kbdr_rd;
   logic       ddr_wr;

   assign kbdr_rd = (mar == KBDR_ADDR) && !memwe && !ld_en;
   assign ddr_wr  = (mar == DDR_ADDR) && memwe && !ld_en;

   // NOTE: every variable gets a default first so this block can never infer a latch.
   always_comb begin
      kbsr_d      = kbsr_q;
      kbdr_d      = kbdr_q;
      dsr_d       = dsr_q;
      cnt_d       = cnt_q;
      ddr_valid_d = 1'b0;
      ddr_data_d  = ddr_data_q;

      // Read-clear happens before the new character is considered, so a
      // same-edge read and offer leaves the buffer full with the new char.
      if (kbdr_rd) kbsr_d = 1'b0;
      if (kbd_valid && !kbsr_d) begin
         kbdr_d = kbd_data;
         kbsr_d = 1'b1;
      end

      if (cnt_q != 8'd0) begin
         cnt_d = cnt_q - 8'd1;
         if (cnt_q == 8'd1) dsr_d = 1'b1;
      end
      if (ddr_wr && dsr_q) begin
         ddr_valid_d = 1'b1;
         ddr_data_d  = wr_char;
         dsr_d       = 1'b0;
         cnt_d       = 8'(DISP_DELAY);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         kbsr_q      <= 1'b0;
         kbdr_q      <= 8'h00;
         dsr_q       <= 1'b1;
         cnt_q       <= 8'd0;
         ddr_valid_q <= 1'b0;
         ddr_data_q  <= 8'h00;
      end else begin
         kbsr_q      <= kbsr_d;
         kbdr_q      <= kbdr_d;
         dsr_q       <= dsr_d;
         cnt_q       <= cnt_d;
         ddr_valid_q <= ddr_valid_d;
         ddr_data_q  <= ddr_data_d;
      end
   end

   always_comb begin
      mmio_rdata = 16'h0000;
      case (mar)
         KBSR_ADDR: mmio_rdata[READY_BIT] = kbsr_q;
         KBDR_ADDR: mmio_rdata = {8'h00, kbdr_q};
         DSR_ADDR:  mmio_rdata[READY_BIT] = dsr_q;
         default:   mmio_rdata = 16'h0000;
      endcase
   end

   assign kbd_ready = ~kbsr_q;
   assign ddr_valid = ddr_valid_q;
   assign ddr_data  = ddr_data_q;

endmodule

// File: rtl/lc3_mem_responder.sv
// LC3 memory-side responder: word RAM with write-first read pipeline,
// bench preload port with priority, and the MMIO device registers.
module lc3_mem_responder
   import lc3_mem_pkg::*;
#(
   parameter int MEM_AW     = 12,
   parameter int READ_LAT   = 1,
   parameter int DISP_DELAY = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] mar,
   input  logic [15:0] mdr,
   input  logic        memwe,
   output logic [15:0] memOut,
   input  logic        ld_en,
   input  logic [15:0] ld_addr,
   input  logic [15:0] ld_data,
   input  logic        kbd_valid,
   input  logic [7:0]  kbd_data,
   output logic        kbd_ready,
   output logic        ddr_valid,
   output logic [7:0]  ddr_data
);

   localparam int DEPTH = 1 << MEM_AW;

   logic [15:0]               mem [DEPTH];
   logic                      wr_en;
   logic [MEM_AW-1:0]         wr_idx;
   logic [15:0]               wr_data;
   logic [MEM_AW-1:0]         rd_idx;
   logic [15:0]               rd_data;
   logic [15:0]               mmio_rdata;
   logic [READ_LAT-1:0][15:0] pipe_q, pipe_d;

   lc3_mmio_regs #(.DISP_DELAY(DISP_DELAY)) u_mmio (
      .clk        (clk),
      .reset      (reset),
      .mar        (mar),
      .wr_char    (mdr[7:0]),
      .memwe      (memwe),
      .ld_en      (ld_en),
      .kbd_valid  (kbd_valid),
      .kbd_data   (kbd_data),
      .kbd_ready  (kbd_ready),
      .ddr_valid  (ddr_valid),
      .ddr_data   (ddr_data),
      .mmio_rdata (mmio_rdata)
   );

   // Preload owns the write port whenever ld_en is high.
   always_comb begin
      if (ld_en) begin
         wr_en   = !is_mmio(ld_addr);
         wr_idx  = ld_addr[MEM_AW-1:0];
         wr_data = ld_data;
      end else begin
         wr_en   = memwe && !is_mmio(mar);
         wr_idx  = mar[MEM_AW-1:0];
         wr_data = mdr;
      end
   end

   // NOTE: RAM has no reset; its contents survive reset and it maps to plain memory.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_idx] <= wr_data;
   end

   assign rd_idx = mar[MEM_AW-1:0];

   // Same-edge write data is forwarded so reads are write-first.
   always_comb begin
      if (is_mmio(mar))                    rd_data = mmio_rdata;
      else if (wr_en && wr_idx == rd_idx)  rd_data = wr_data;
      else                                 rd_data = mem[rd_idx];
   end

   always_comb begin
      pipe_d    = pipe_q;
      pipe_d[0] = rd_data;
      for (int i = 1; i < READ_LAT; i++) pipe_d[i] = pipe_q[i-1];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) pipe_q <= '0;
      else        pipe_q <= pipe_d;
   end

   assign memOut = pipe_q[READ_LAT-1];

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Self-checking bench: table of per-edge vectors feeding two responders
// (latency 1 and 3) with a per-latency scoreboard queue for memOut.
module tb_lc3_mem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] mar, mdr, ld_addr, ld_data;
   logic        memwe, ld_en, kbd_valid;
   logic [7:0]  kbd_data;
   logic [15:0] mem_out1, mem_out3;
   logic        kbd_ready1, kbd_ready3, ddr_valid1, ddr_valid3;
   logic [7:0]  ddr_data1, ddr_data3;

   int n_vec  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   lc3_mem_responder #(.MEM_AW(12), .READ_LAT(1), .DISP_DELAY(4)) dut1 (
      .clk(clk), .reset(reset), .mar(mar), .mdr(mdr), .memwe(memwe), .memOut(mem_out1),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .kbd_valid(kbd_valid),
      .kbd_data(kbd_data), .kbd_ready(kbd_ready1), .ddr_valid(ddr_valid1), .ddr_data(ddr_data1)
   );

   lc3_mem_responder #(.MEM_AW(12), .READ_LAT(3), .DISP_DELAY(4)) dut3 (
      .clk(clk), .reset(reset), .mar(mar), .mdr(mdr), .memwe(memwe), .memOut(mem_out3),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .kbd_valid(kbd_valid),
      .kbd_data(kbd_data), .kbd_ready(kbd_ready3), .ddr_valid(ddr_valid3), .ddr_data(ddr_data3)
   );

   typedef struct {
      string       name;
      logic [15:0] mar;
      logic [15:0] mdr;
      logic        we;
      logic        ld;
      logic [15:0] la;
      logic [15:0] ldd;
      logic        kv;
      logic [7:0]  kd;
      logic        chk;
      logic [15:0] exp;
      logic        kr;
      logic        dv;
      logic [7:0]  dd;
   } vec_t;

   typedef struct {
      string       name;
      logic        chk;
      logic [15:0] exp;
   } sb_t;

   vec_t tbl[$];
   sb_t  q1[$];
   sb_t  q3[$];

   function automatic vec_t mk(input string n, input logic [15:0] a, input logic [15:0] d,
                               input logic we, input logic ld, input logic [15:0] la,
                               input logic [15:0] ldd, input logic kv, input logic [7:0] kd,
                               input logic chk, input logic [15:0] exp, input logic kr,
                               input logic dv, input logic [7:0] dd);
      vec_t v;
      v.name = n; v.mar = a; v.mdr = d; v.we = we; v.ld = ld; v.la = la; v.ldd = ldd;
      v.kv = kv; v.kd = kd; v.chk = chk; v.exp = exp; v.kr = kr; v.dv = dv; v.dd = dd;
      return v;
   endfunction

   // Plain read of address a with expected data e.
   function automatic vec_t rd(input string n, input logic [15:0] a, input logic [15:0] e,
                               input logic kr);
      return mk(n, a, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 8'h00,
                1'b1, e, kr, 1'b0, 8'h00);
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      sb_t e;
      @(negedge clk);
      mar = v.mar; mdr = v.mdr; memwe = v.we; ld_en = v.ld; ld_addr = v.la;
      ld_data = v.ldd; kbd_valid = v.kv; kbd_data = v.kd;
      @(posedge clk);
      #1;
      e.name = v.name; e.chk = v.chk; e.exp = v.exp;
      q1.push_back(e);
      q3.push_back(e);
      if (q1.size() >= 1) begin
         e = q1.pop_front();
         if (e.chk) check({e.name, "/lat1"}, mem_out1, e.exp);
      end
      if (q3.size() >= 3) begin
         e = q3.pop_front();
         if (e.chk) check({e.name, "/lat3"}, mem_out3, e.exp);
      end
      check({v.name, "/kbd_ready"}, 16'(kbd_ready1), 16'(v.kr));
      check({v.name, "/ddr_valid"}, 16'(ddr_valid1), 16'(v.dv));
      if (v.dv) check({v.name, "/ddr_data"}, 16'(ddr_data1), 16'(v.dd));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "bench timed out");
   end

   initial begin
      reset = 1'b0; mar = 16'h0100; mdr = 16'h0000; memwe = 1'b0; ld_en = 1'b0;
      ld_addr = 16'h0000; ld_data = 16'h0000; kbd_valid = 1'b0; kbd_data = 8'h00;

      //            name            mar       mdr       we    ld    ld_addr   ld_data   kv    kd     chk   exp       kr    dv    dd
      tbl.push_back(mk("preload",   16'h0100, 16'h0000, 1'b0, 1'b1, 16'h3000, 16'h1234, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h00));
      tbl.push_back(rd("rd_3000",   16'h3000, 16'h1234, 1'b1));
      tbl.push_back(mk("wr_fwd",    16'h3001, 16'hBEEF, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 8'h00, 1'b1, 16'hBEEF, 1'b1, 1'b0, 8'h00));
      tbl.push_back(rd("alias",     16'h4001, 16'hBEEF, 1'b1));
      tbl.push_back(rd("dsr_idle",  16'hFE04, 16'h8000, 1'b1));
      tbl.push_back(rd("kbsr_empty",16'hFE00, 16'h0000, 1'b1));
      tbl.push_back(mk("kbd_in",    16'h3000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 8'h41, 1'b1, 16'h1234, 1'b0, 1'b0, 8'h00));
      tbl.push_back(rd("kbsr_full", 16'hFE00, 16'h8000, 1'b0));
      tbl.push_back(mk("kbd_drop",  16'h3001, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 8'h42, 1'b1, 16'hBEEF, 1'b0, 1'b0, 8'h00));
      tbl.push_back(rd("kbdr_rd",   16'hFE02, 16'h0041, 1'b1));
      tbl.push_back(rd("kbsr_clr",  16'hFE00, 16'h0000, 1'b1));
      tbl.push_back(rd("kbdr_again",16'hFE02, 16'h0041, 1'b1));
      tbl.push_back(mk("ddr_wr",    16'hFE06, 16'h0048, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 8'h00, 1'b1, 16'h0000, 1'b1, 1'b1, 8'h48));
      tbl.push_back(rd("dsr_busy1", 16'hFE04, 16'h0000, 1'b1));
      tbl.push_back(mk("ddr_busy",  16'hFE06, 16'h0049, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 8'h00, 1'b1, 16'h0000, 1'b1, 1'b0, 8'h00));
      tbl.push_back(rd("dsr_busy3", 16'hFE04, 16'h0000, 1'b1));
      tbl.push_back(rd("dsr_busy4", 16'hFE04, 16'h0000, 1'b1));
      tbl.push_back(rd("dsr_ready", 16'hFE04, 16'h8000, 1'b1));
      tbl.push_back(mk("ld_prio",   16'h3002, 16'hAAAA, 1'b1, 1'b1, 16'h3002, 16'h5555, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h00));
      tbl.push_back(rd("rd_3002",   16'h3002, 16'h5555, 1'b1));
      tbl.push_back(mk("ld_e02",    16'h0100, 16'h0000, 1'b0, 1'b1, 16'h0E02, 16'h7777, 1'b1, 8'h43, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00));
      tbl.push_back(mk("ld_mmio",   16'hFE02, 16'h0000, 1'b0, 1'b1, 16'hFE02, 16'h9999, 1'b0, 8'h00, 1'b1, 16'h0043, 1'b0, 1'b0, 8'h00));
      tbl.push_back(rd("rd_0e02",   16'h0E02, 16'h7777, 1'b0));
      tbl.push_back(mk("kbd_same",  16'hFE02, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 8'h44, 1'b1, 16'h0043, 1'b0, 1'b0, 8'h00));
      tbl.push_back(rd("kbdr_new",  16'hFE02, 16'h0044, 1'b1));
      tbl.push_back(mk("wr_kbsr",   16'hFE00, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 8'h00, 1'b1, 16'h0000, 1'b1, 1'b0, 8'h00));
      tbl.push_back(rd("kbsr_after",16'hFE00, 16'h0000, 1'b1));

      repeat (3) @(posedge clk);
      #1;
      check("reset/memOut_lat1", mem_out1, 16'h0000);
      check("reset/memOut_lat3", mem_out3, 16'h0000);
      check("reset/kbd_ready", {14'h0, kbd_ready1, kbd_ready3}, 16'h0003);
      check("reset/ddr_valid", {14'h0, ddr_valid1, ddr_valid3}, 16'h0000);
      check("reset/ddr_data", {ddr_data1, ddr_data3}, 16'h0000);
      @(negedge clk);
      reset = 1'b1;

      foreach (tbl[i]) apply(tbl[i]);

      // Reset in the middle of a display delay with the keyboard buffer full.
      apply(mk("pre_rst_ddr", 16'hFE06, 16'h0050, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 8'h45,
               1'b0, 16'h0000, 1'b0, 1'b1, 8'h50));
      apply(rd("pre_rst_rd", 16'h3000, 16'h1234, 1'b0));
      reset = 1'b0;
      #2;
      check("midrst/memOut_lat1", mem_out1, 16'h0000);
      check("midrst/memOut_lat3", mem_out3, 16'h0000);
      check("midrst/kbd_ready", 16'(kbd_ready1), 16'h0001);
      check("midrst/ddr_valid", 16'(ddr_valid1), 16'h0000);
      q1.delete();
      q3.delete();
      @(negedge clk);
      reset = 1'b1;
      apply(rd("post_rst_dsr",  16'hFE04, 16'h8000, 1'b1));
      apply(rd("post_rst_kbsr", 16'hFE00, 16'h0000, 1'b1));
      apply(rd("post_rst_ram",  16'h3000, 16'h1234, 1'b1));
      apply(rd("post_rst_ram2", 16'h3001, 16'hBEEF, 1'b1));
      repeat (2) apply(mk("flush", 16'h3002, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0,
                          8'h00, 1'b1, 16'h5555, 1'b1, 1'b0, 8'h00));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/lc3_mem_responder.md
Name: lc3_mem_responder

Overview:
- Memory-side responder for the LC3 bus: consumes mar/mdr/memwe from the processor and returns memOut.
- Contains word-addressed RAM with configurable read latency, LC3 memory-mapped keyboard/display registers, and a bench preload port.
- Sits on the DUT2MEM side of test_if. Replaces any combinational memory stub with cycle-accurate sequential behaviour.

Parameters:
- MEM_AW, 12, RAM address bits; depth = 2**MEM_AW words of 16 bits.
- READ_LAT, 1, read latency in clock edges; legal range 1..4.
- DISP_DELAY, 4, cycles DSR stays not-ready after a DDR write; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- mar  in  16  address from processor.
- mdr  in  16  write data from processor.
- memwe  in  1  write enable, sampled at rising edge.
- memOut  out  16  read data.
- ld_en  in  1  bench preload strobe.
- ld_addr  in  16  preload address.
- ld_data  in  16  preload data.
- kbd_valid  in  1  keyboard character offered.
- kbd_data  in  8  keyboard character.
- kbd_ready  out  1  high when the keyboard buffer is empty (= ~KBSR[15]).
- ddr_valid  out  1  one-cycle pulse when a character is displayed.
- ddr_data  out  8  displayed character.

Behaviour:
- Reset (async, reset=0):
  - memOut=0 and all read pipeline stages cleared.
  - KBSR[15]=0, KBDR=0, DSR[15]=1, display counter=0, ddr_valid=0, ddr_data=0.
  - RAM contents are not cleared.
  - Reset asserted mid-delay returns DSR to ready immediately.
- Address decode:
  - MMIO window is x0FE00-xFFFF.
  - All other addresses index RAM[mar[MEM_AW-1:0]], i.e. aliasing modulo depth.
- RAM write: at a rising edge with memwe=1, ld_en=0 and mar outside MMIO, RAM[idx] <= mdr.
- Read timing:
  - The address is sampled every edge. The read is write-first: data written at edge k is visible to a read of the same address at edge k.
  - The value appears on memOut after edge k+READ_LAT-1. With READ_LAT=1, memOut updates at the sampling edge.
  - Pipeline stages shift every cycle; there is no stall input.
- MMIO reads (memOut value):
  - xFE00 KBSR returns {KBSR[15],15'b0}.
  - xFE02 KBDR returns {8'h00,KBDR}.
  - xFE04 DSR returns {DSR[15],15'b0}.
  - xFE06 DDR returns 0.
  - Any other MMIO address returns 0.
- Keyboard:
  - When kbd_valid=1 and KBSR[15]=0: KBDR<=kbd_data and KBSR[15]<=1.
  - When kbd_valid=1 and KBSR[15]=1: the character is dropped.
  - Any edge with mar=xFE02, memwe=0, ld_en=0 clears KBSR[15]. The clear is idempotent across repeated cycles.
  - Same-edge KBDR read and kbd_valid while full: the clear is applied first, then the new character is latched. Result: KBSR[15]=1, KBDR=new char; memOut for that read carries the old char.
- Display:
  - A write to xFE06 with DSR[15]=1 produces ddr_valid=1 and ddr_data=mdr[7:0] for exactly one cycle after the edge.
  - The same write sets DSR[15]=0 and loads the counter with DISP_DELAY.
  - The counter decrements each cycle; DSR[15] returns to 1 on the edge where it reaches 0.
  - A write to DDR while DSR[15]=0 is ignored (no pulse, counter untouched).
- Writes to KBSR, KBDR, DSR, or unmapped MMIO are discarded.
- Preload:
  - ld_en=1 writes RAM[ld_addr[MEM_AW-1:0]] <= ld_data.
  - ld_en takes priority over memwe in the same cycle; the processor write is dropped.
  - A preload to the MMIO window is ignored.
  - MMIO read side effects are suppressed while ld_en=1.

Decomposition:
- Package lc3_mem_pkg holds:
  - MMIO constants: KBSR_ADDR=xFE00, KBDR_ADDR=xFE02, DSR_ADDR=xFE04, DDR_ADDR=xFE06, MMIO_BASE=xFE00.
  - Ready-bit index 15.
  - Function is_mmio(addr).
- Sub-module lc3_mmio_regs holds the keyboard buffer, display counter and DSR, and produces MMIO read data.
- The top level holds the RAM, decode, preload arbitration and read pipeline.

Test Plan:
- Preload x3000=x1234; READ_LAT=1; mar=x3000, memwe=0 -> memOut=x1234 after the first edge. With READ_LAT=3, memOut=x1234 only after the third edge.
- Same edge memwe=1, mar=x3001, mdr=xBEEF -> memOut=xBEEF (write-first). Then read mar=x3001+2**MEM_AW -> xBEEF via aliasing.
- kbd_valid with kbd_data=x41 -> kbd_ready=0; read xFE00 -> x8000; read xFE02 -> x0041, then KBSR reads x0000. Offer x42 while full -> dropped, KBDR stays x41.
- Write xFE06 with mdr=x0048 -> ddr_valid pulse with ddr_data=x48; DSR reads x0000 for DISP_DELAY cycles, then x8000. A second DDR write during the delay produces no pulse.
- ld_en=1 (ld_addr=x3002, ld_data=x5555) together with memwe=1 (mar=x3002, mdr=xAAAA) -> RAM[x3002]=x5555.
- Assert reset mid-display-delay and with KBSR full -> DSR=x8000, KBSR=0, memOut=0; RAM x3000 still returns x1234.
